// File: rtl/writeback_arbiter.sv
// Register-file write-back arbiter: one holding entry per result source, round-robin
// onto the single write port, with a busy flag and a retired-result counter.

package cpu_parameters;
  localparam int xlen = 32;
endpackage

module writeback_arbiter
  import cpu_parameters::*;
#(
  parameter int NSRC  = 3,
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NSRC-1:0]      src_valid,
  output logic [NSRC-1:0]      src_ready,
  input  logic [NSRC*5-1:0]    src_rd,
  input  logic [NSRC*xlen-1:0] src_data,
  output logic                 w_valid,
  output logic [4:0]           w_ad,
  output logic [xlen-1:0]      w_data,
  output logic                 wb_busy,
  output logic [CNT_W-1:0]     retire_cnt
);

  localparam int PTR_W = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic [NSRC-1:0]  held;
  logic [4:0]       rd_q   [NSRC];
  logic [xlen-1:0]  data_q [NSRC];
  logic [PTR_W-1:0] rr_ptr;

  logic [NSRC-1:0]  grant;
  logic [PTR_W-1:0] g_idx;
  logic             found;
  logic [NSRC-1:0]  accept;
  logic [CNT_W-1:0] accept_cnt;

  // Source index k steps after the pointer, wrapped into 0..NSRC-1.
  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NSRC) s = s - NSRC;
    return PTR_W'(s);
  endfunction

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    grant = '0;
    g_idx = '0;
    found = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (!found && held[wrap_idx(rr_ptr, k)]) begin
        found                   = 1'b1;
        g_idx                   = wrap_idx(rr_ptr, k);
        grant[wrap_idx(rr_ptr, k)] = 1'b1;
      end
    end
  end

  assign src_ready = ~held | grant;
  assign accept    = src_valid & src_ready;
  assign wb_busy   = |held;
  assign w_valid   = found;
  assign w_ad      = found ? rd_q[g_idx]   : 5'd0;
  assign w_data    = found ? data_q[g_idx] : '0;

  always_comb begin
    accept_cnt = '0;
    for (int i = 0; i < NSRC; i++) accept_cnt = accept_cnt + CNT_W'(accept[i]);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held       <= '0;
      rr_ptr     <= '0;
      retire_cnt <= '0;
      // NOTE: the holding arrays are reset too; they are flops, not RAM, and must read zero after reset.
      for (int i = 0; i < NSRC; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (accept[i]) begin
          // A write to x0 is retired without occupying the entry.
          held[i] <= (src_rd[5*i +: 5] != 5'd0);
          if (src_rd[5*i +: 5] != 5'd0) begin
            rd_q[i]   <= src_rd[5*i +: 5];
            data_q[i] <= src_data[xlen*i +: xlen];
          end
        end else if (grant[i]) begin
          held[i] <= 1'b0;
        end
      end
      if (found) rr_ptr <= (g_idx == PTR_W'(NSRC - 1)) ? '0 : g_idx + PTR_W'(1);
      retire_cnt <= retire_cnt + accept_cnt;
    end
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios plus random traffic,
// compared every cycle against a behavioural model of the holding entries.

module tb_writeback_arbiter;
  import cpu_parameters::*;

  localparam int NSRC  = 3;
  localparam int CNT_W = 4;
  localparam int XLEN  = xlen;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NSRC-1:0]      src_valid;
  logic [NSRC-1:0]      src_ready;
  logic [NSRC*5-1:0]    src_rd;
  logic [NSRC*XLEN-1:0] src_data;
  logic                 w_valid;
  logic [4:0]           w_ad;
  logic [XLEN-1:0]      w_data;
  logic                 wb_busy;
  logic [CNT_W-1:0]     retire_cnt;

  writeback_arbiter #(.NSRC(NSRC), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .src_rd     (src_rd),
    .src_data   (src_data),
    .w_valid    (w_valid),
    .w_ad       (w_ad),
    .w_data     (w_data),
    .wb_busy    (wb_busy),
    .retire_cnt (retire_cnt)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: one slot per source, pointer and retire count as plain integers.
  bit            m_held [NSRC];
  int            m_rd   [NSRC];
  logic [31:0]   m_data [NSRC];
  int            m_ptr;
  int            m_cnt;

  function automatic void model_reset();
    for (int i = 0; i < NSRC; i++) begin
      m_held[i] = 0;
      m_rd[i]   = 0;
      m_data[i] = '0;
    end
    m_ptr = 0;
    m_cnt = 0;
  endfunction

  function automatic int model_grant();
    for (int k = 0; k < NSRC; k++)
      if (m_held[(m_ptr + k) % NSRC]) return (m_ptr + k) % NSRC;
    return -1;
  endfunction

  // Compare outputs for the current cycle, then apply new inputs and advance the model.
  task automatic cycle(input logic [NSRC-1:0] v, input logic [NSRC*5-1:0] rd,
                       input logic [NSRC*XLEN-1:0] d);
    int g;
    logic [NSRC-1:0] rdy;
    @(negedge clk);
    g = model_grant();
    for (int i = 0; i < NSRC; i++) rdy[i] = !m_held[i] || (i == g);
    check("w_valid",    64'(w_valid),    64'(g >= 0));
    check("w_ad",       64'(w_ad),       (g >= 0) ? 64'(m_rd[g])   : 64'd0);
    check("w_data",     64'(w_data),     (g >= 0) ? 64'(m_data[g]) : 64'd0);
    check("wb_busy",    64'(wb_busy),    64'(m_held[0] || m_held[1] || m_held[2]));
    check("retire_cnt", 64'(retire_cnt), 64'(m_cnt));
    check("src_ready",  64'(src_ready),  64'(rdy));
    src_valid = v;
    src_rd    = rd;
    src_data  = d;
    for (int i = 0; i < NSRC; i++) begin
      if (v[i] && rdy[i]) begin
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
        if (rd[5*i +: 5] != 5'd0) begin
          m_held[i] = 1;
          m_rd[i]   = int'(rd[5*i +: 5]);
          m_data[i] = d[XLEN*i +: XLEN];
        end else begin
          m_held[i] = 0;
        end
      end else if (i == g) begin
        m_held[i] = 0;
      end
    end
    if (g >= 0) m_ptr = (g + 1) % NSRC;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0, '0, '0);
  endtask

  // Let the pending edge happen and sample just after it.
  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock.
  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_w_valid",  64'(w_valid),    64'd0);
    check("rst_w_ad",     64'(w_ad),       64'd0);
    check("rst_w_data",   64'(w_data),     64'd0);
    check("rst_busy",     64'(wb_busy),    64'd0);
    check("rst_cnt",      64'(retire_cnt), 64'd0);
    check("rst_ready",    64'(src_ready),  64'b111);
    model_reset();
    @(negedge clk);
    src_valid = '0;
    src_rd    = '0;
    src_data  = '0;
    #2 rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    src_valid = '0;
    src_rd    = '0;
    src_data  = '0;
    model_reset();
    #1;
    check("init_w_valid", 64'(w_valid),   64'd0);
    check("init_ready",   64'(src_ready), 64'b111);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Single ALU result to x5.
    cycle(3'b001, {5'd0, 5'd0, 5'd5}, {32'd0, 32'd0, 32'hDEADBEEF});
    idle(2);
    settle();
    check("t2_cnt", 64'(retire_cnt), 64'd1);

    // Three-way contention from a fresh pointer.
    do_reset();
    cycle(3'b111, {5'd3, 5'd2, 5'd1}, {32'h33333333, 32'h22222222, 32'h11111111});
    idle(4);

    // ALU streaming back-to-back.
    for (int i = 0; i < 8; i++)
      cycle(3'b001, {10'd0, 5'(i + 8)}, {64'd0, $urandom});
    idle(2);

    // LSU result to x0 is retired but never written.
    cycle(3'b010, {5'd0, 5'd0, 5'd0}, {32'd0, 32'h00001234, 32'd0});
    idle(1);
    settle();
    check("x0_busy", 64'(wb_busy), 64'd0);
    check("x0_cnt",  64'(retire_cnt), 64'(m_cnt));

    // Counter wrap: 17 accepted results on a 4-bit counter.
    do_reset();
    for (int i = 0; i < 17; i++) cycle(3'b001, {10'd0, 5'd7}, {64'd0, 32'(i)});
    idle(1);
    settle();
    check("wrap_cnt", 64'(retire_cnt), 64'd1);

    // Random traffic, x0 destinations included.
    for (int i = 0; i < 400; i++) begin
      logic [NSRC*5-1:0] rd;
      rd = 15'($urandom);
      if ($urandom_range(0, 7) == 0) rd[5*$urandom_range(0, 2) +: 5] = 5'd0;
      cycle(3'($urandom_range(0, 7)), rd, {$urandom, $urandom, $urandom});
    end

    // Reset with entries held; nothing may be written afterwards.
    cycle(3'b111, {5'd9, 5'd10, 5'd11}, {$urandom, $urandom, $urandom});
    do_reset();
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
